// File: rtl/time_align_nstage_if.sv
// Stage-code input and aligned-sample output bundle for time_align_nstage.
interface time_align_nstage_if #(
  parameter int NUM_STAGES = 4,
  parameter int STAGE_BITS = 3,
  parameter int REDUNDANCY = 0
);
  localparam int OUT_W = (REDUNDANCY != 0) ?
                         (NUM_STAGES - 1) * (STAGE_BITS - 1) + STAGE_BITS :
                         NUM_STAGES * STAGE_BITS;

  logic                             valid_i;
  logic [NUM_STAGES*STAGE_BITS-1:0] stage_i;
  logic [OUT_W-1:0]                 dout_o;
  logic                             valid_o;
  logic                             ovf_o;

  modport master (
    output valid_i, stage_i,
    input  dout_o, valid_o, ovf_o
  );

  modport slave (
    input  valid_i, stage_i,
    output dout_o, valid_o, ovf_o
  );
endinterface

// File: rtl/time_align_nstage.sv
// N-stage time alignment and digital error correction for the pipelined ADC
// back end. Stage k is delayed NUM_STAGES-1-k registers so that all codes of
// one sample meet, then they are concatenated or overlap-added with saturation.
module time_align_nstage #(
  parameter int NUM_STAGES = 4,
  parameter int STAGE_BITS = 3,
  parameter int REDUNDANCY = 0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  time_align_nstage_if.slave  bus
);
  localparam int OUT_W = (REDUNDANCY != 0) ?
                         (NUM_STAGES - 1) * (STAGE_BITS - 1) + STAGE_BITS :
                         NUM_STAGES * STAGE_BITS;
  localparam int SUM_W = OUT_W + 1;
  localparam int DEPTH = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0][STAGE_BITS-1:0] aligned;
  logic [DEPTH-1:0]                      vpipe;
  logic                                  vdly;
  logic [OUT_W-1:0]                      merged;
  logic                                  merged_ovf;
  logic [OUT_W-1:0]                      dout;
  logic                                  valid;
  logic                                  ovf;

  // Triangular delay structure: the last stage passes straight through.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int D = NUM_STAGES - 1 - k;
    logic [STAGE_BITS-1:0] code;
    assign code = bus.stage_i[(NUM_STAGES-k)*STAGE_BITS-1 -: STAGE_BITS];

    if (D == 0) begin : g_direct
      assign aligned[k] = code;
    end else begin : g_delay
      logic [STAGE_BITS-1:0] sr [D];

      // Free-running shift of this stage's code, independent of valid.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          for (int unsigned i = 0; i < D; i++) sr[i] <= '0;
        end else begin
          sr[0] <= code;
          for (int unsigned i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end

      assign aligned[k] = sr[D-1];
    end
  end

  // Valid follows the stage-0 code through NUM_STAGES-1 registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= bus.valid_i;
      for (int unsigned i = 1; i < DEPTH; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  assign vdly = vpipe[DEPTH-1];

  if (REDUNDANCY != 0) begin : g_red
    logic [SUM_W-1:0] sum;

    // Overlapped add; the sum always fits in OUT_W+1 bits, so the top bit
    // alone flags saturation.
    always_comb begin
      sum = '0;
      for (int unsigned k = 0; k < NUM_STAGES; k++)
        sum = sum + (SUM_W'(aligned[k]) << ((NUM_STAGES - 1 - k) * (STAGE_BITS - 1)));
      merged_ovf = sum[OUT_W];
      merged     = merged_ovf ? '1 : sum[OUT_W-1:0];
    end
  end else begin : g_cat
    // Plain concatenation, stage 0 in the MSBs.
    always_comb begin
      merged     = '0;
      merged_ovf = 1'b0;
      for (int unsigned k = 0; k < NUM_STAGES; k++)
        merged[(NUM_STAGES-k)*STAGE_BITS-1 -: STAGE_BITS] = aligned[k];
    end
  end

  // Output register: loads on delayed valid, otherwise holds.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dout  <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= vdly;
      if (vdly) begin
        dout <= merged;
        ovf  <= merged_ovf;
      end
    end
  end

  assign bus.dout_o  = dout;
  assign bus.valid_o = valid;
  assign bus.ovf_o   = ovf;
endmodule

// File: tb/tb_time_align_nstage.sv
// Bench for time_align_nstage: three instances (2-stage concat, 4-stage
// redundant, 4-stage concat) driven in lockstep, compared every cycle
// against a per-sample reference built from recorded input history.
module tb_time_align_nstage;
  localparam int MAXE = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  time_align_nstage_if #(.NUM_STAGES(2), .STAGE_BITS(3), .REDUNDANCY(0)) bus_a ();
  time_align_nstage_if #(.NUM_STAGES(4), .STAGE_BITS(3), .REDUNDANCY(1)) bus_b ();
  time_align_nstage_if #(.NUM_STAGES(4), .STAGE_BITS(3), .REDUNDANCY(0)) bus_c ();

  time_align_nstage #(.NUM_STAGES(2), .STAGE_BITS(3), .REDUNDANCY(0))
    dut_a (.clk_i(clk), .reset_i(rst), .bus(bus_a));
  time_align_nstage #(.NUM_STAGES(4), .STAGE_BITS(3), .REDUNDANCY(1))
    dut_b (.clk_i(clk), .reset_i(rst), .bus(bus_b));
  time_align_nstage #(.NUM_STAGES(4), .STAGE_BITS(3), .REDUNDANCY(0))
    dut_c (.clk_i(clk), .reset_i(rst), .bus(bus_c));

  int    n_of  [3] = '{2, 4, 4};
  int    red_of[3] = '{0, 1, 0};
  string name  [3] = '{"a", "b", "c"};

  // Input history per edge
  logic [11:0] st_h   [3][MAXE];
  bit          v_h    [3][MAXE];
  bit          rst_at [MAXE];
  bit          clr_bef[MAXE];

  // Directed overrides: per DUT, per edge, per stage field
  bit          ov_en  [3][MAXE+8][4];
  logic [2:0]  ov_code[3][MAXE+8][4];
  bit          ov_v   [3][MAXE+8];

  // Reference outputs
  logic [11:0] exp_d[3];
  bit          exp_o[3];
  bit          exp_v[3];

  int e = 0;
  bit rand_valid = 0;
  bit clr_pend = 0;
  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
  endtask

  task automatic launch(input int d, input int c0, input int c1, input int c2, input int c3);
    int c[4];
    c = '{c0, c1, c2, c3};
    ov_v[d][e] = 1'b1;
    for (int k = 0; k < n_of[d]; k++) begin
      ov_en[d][e+k][k]   = 1'b1;
      ov_code[d][e+k][k] = c[k][2:0];
    end
  endtask

  // Reference: the sample launched at edge t-(N-1) emerges at edge t
  // unless a reset touched any edge interval in between.
  task automatic model_edge(input int t);
    for (int d = 0; d < 3; d++) begin
      int n, s, outw;
      bit ok;
      longint sum, w, c;
      n = n_of[d];
      if (clr_bef[t]) begin
        exp_d[d] = '0;
        exp_o[d] = 1'b0;
      end
      exp_v[d] = 1'b0;
      s = t - (n - 1);
      if (!rst_at[t] && s >= 0 && v_h[d][s]) begin
        ok = !rst_at[s];
        for (int j = s + 1; j <= t; j++) if (clr_bef[j]) ok = 1'b0;
        if (ok) begin
          sum = 0;
          w = 0;
          for (int k = 0; k < n; k++) begin
            c = longint'((st_h[d][s+k] >> ((n - 1 - k) * 3)) & 12'h7);
            w = w * 8 + c;
            sum = sum + (c << ((n - 1 - k) * 2));
          end
          exp_v[d] = 1'b1;
          if (red_of[d] != 0) begin
            outw = (n - 1) * 2 + 3;
            if (sum > (longint'(1) << outw) - 1) begin
              exp_d[d] = 12'((longint'(1) << outw) - 1);
              exp_o[d] = 1'b1;
            end else begin
              exp_d[d] = 12'(sum);
              exp_o[d] = 1'b0;
            end
          end else begin
            exp_d[d] = 12'(w);
            exp_o[d] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic check_outputs(input string when_tag);
    for (int d = 0; d < 3; d++) begin
      logic [15:0] od;
      logic ov, oo;
      case (d)
        0:       begin od = 16'(bus_a.dout_o); ov = bus_a.valid_o; oo = bus_a.ovf_o; end
        1:       begin od = 16'(bus_b.dout_o); ov = bus_b.valid_o; oo = bus_b.ovf_o; end
        default: begin od = 16'(bus_c.dout_o); ov = bus_c.valid_o; oo = bus_c.ovf_o; end
      endcase
      check($sformatf("%s_dout_%s%0d", name[d], when_tag, e), od, 16'(exp_d[d]));
      check($sformatf("%s_valid_%s%0d", name[d], when_tag, e), 16'(ov), 16'(exp_v[d]));
      check($sformatf("%s_ovf_%s%0d", name[d], when_tag, e), 16'(oo), 16'(exp_o[d]));
    end
  endtask

  task automatic tick();
    for (int d = 0; d < 3; d++) begin
      logic [11:0] word;
      int n;
      bit v;
      n = n_of[d];
      word = 12'($urandom) & 12'((1 << (n * 3)) - 1);
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ov_v[d][e]) v = 1'b1;
      for (int k = 0; k < n; k++)
        if (ov_en[d][e][k]) word[(n-k)*3-1 -: 3] = ov_code[d][e][k];
      st_h[d][e] = word;
      v_h[d][e]  = v;
    end
    bus_a.valid_i = v_h[0][e];
    bus_a.stage_i = st_h[0][e][5:0];
    bus_b.valid_i = v_h[1][e];
    bus_b.stage_i = st_h[1][e];
    bus_c.valid_i = v_h[2][e];
    bus_c.stage_i = st_h[2][e];
    rst_at[e]  = rst;
    clr_bef[e] = rst || clr_pend;
    clr_pend   = 1'b0;
    @(posedge clk);
    model_edge(e);
    e++;
    #1;
    check_outputs("e");
  endtask

  // Asynchronous reset pulse wholly between two clock edges.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    clr_pend = 1'b1;
    #1;
    check("a_dout_async", 16'(bus_a.dout_o), 16'h0);
    check("b_dout_async", 16'(bus_b.dout_o), 16'h0);
    check("b_ovf_async", 16'(bus_b.ovf_o), 16'h0);
    check("c_dout_async", 16'(bus_c.dout_o), 16'h0);
    check("c_valid_async", 16'(bus_c.valid_o), 16'h0);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      exp_d[d] = '0;
      exp_o[d] = 1'b0;
      exp_v[d] = 1'b0;
    end
    bus_a.valid_i = 1'b0; bus_a.stage_i = '0;
    bus_b.valid_i = 1'b0; bus_b.stage_i = '0;
    bus_c.valid_i = 1'b0; bus_c.stage_i = '0;

    // Reset held over several edges, with valid_i driven high meanwhile
    launch(0, 7, 7, 0, 0);
    launch(1, 7, 7, 7, 7);
    launch(2, 7, 7, 7, 7);
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();

    // 2-stage concat and 4-stage redundant directed samples
    launch(0, 5, 3, 0, 0);
    launch(1, 2, 3, 1, 2);
    tick();
    tick();
    check("a_dir_dout", 16'(bus_a.dout_o), 16'b101011);
    check("a_dir_valid", 16'(bus_a.valid_o), 16'h1);
    tick();
    check("a_dir_pulse_end", 16'(bus_a.valid_o), 16'h0);
    tick();
    check("b_dir_dout", 16'(bus_b.dout_o), 16'd182);
    check("b_dir_ovf", 16'(bus_b.ovf_o), 16'h0);
    check("b_dir_valid", 16'(bus_b.valid_o), 16'h1);

    // Saturation then recovery
    launch(1, 7, 7, 7, 7);
    tick();
    launch(1, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    check("b_sat_dout", 16'(bus_b.dout_o), 16'd511);
    check("b_sat_ovf", 16'(bus_b.ovf_o), 16'h1);
    tick();
    check("b_zero_dout", 16'(bus_b.dout_o), 16'd0);
    check("b_zero_ovf", 16'(bus_b.ovf_o), 16'h0);
    tick();
    tick();

    // Streaming: 6 back-to-back, 2 idle, 1 more
    for (int i = 0; i < 6; i++) begin
      launch(2, i, (i + 1) % 8, (i + 2) % 8, 7 - i);
      tick();
    end
    tick();
    tick();
    launch(2, 6, 5, 4, 3);
    tick();
    tick();
    tick();
    check("c_stream_last_valid", 16'(bus_c.valid_o), 16'h0);
    tick();
    check("c_stream_last_dout", 16'(bus_c.dout_o), 16'o6543);
    check("c_stream_last_vld", 16'(bus_c.valid_o), 16'h1);
    tick();
    tick();

    // Reset mid-operation: sample A killed, sample B launched 2 edges after release
    launch(1, 3, 3, 3, 3);
    launch(2, 1, 2, 3, 4);
    tick();
    tick();
    pulse_reset();
    tick();
    launch(1, 1, 1, 1, 1);
    launch(2, 4, 3, 2, 1);
    tick();
    tick();
    tick();
    check("c_rst_pre_b_valid", 16'(bus_c.valid_o), 16'h0);
    tick();
    check("c_rst_b_dout", 16'(bus_c.dout_o), 16'o4321);
    check("c_rst_b_valid", 16'(bus_c.valid_o), 16'h1);
    check("b_rst_b_dout", 16'(bus_b.dout_o), 16'd85);
    tick();
    tick();

    // Randomized streaming with occasional resets
    rand_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset();
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end
    rand_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog in case the clock or a task stalls
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
